// File: rtl/poly_mult_result_reader.sv
// poly_mult_result_reader
//   Unloads the product held in poly_mult's result RAM after the multiplier
//   raises mult_valid. Every result word is read, the pad bits above N in the
//   final word are cleared, and each word is byte-reversed. The words are then
//   streamed out over a valid/ready port at one word per clock when the
//   downstream side does not stall.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     mult_valid   multiplier done level; a rising edge starts a readout
//     abort        synchronous flush back to IDLE
//     addr_result  result RAM word address (registered)
//     rd_dout      result RAM read enable (registered)
//     dout         result RAM data, valid one clock after addr_result/rd_dout
//     m_data       byte-reversed, tail-masked result word
//     m_valid      m_data valid
//     m_ready      downstream accept
//     m_last       high with the final word
//     busy         readout in progress
//     done         one-clock pulse after the final handshake
//
//   Handshake: a beat transfers on every rising clk edge where m_valid and
//   m_ready are both high. While m_valid is high and m_ready is low, m_data,
//   m_last and m_valid hold their values until the transfer takes place.
module poly_mult_result_reader #(
   parameter int N          = 17669,
   parameter int RAMWIDTH   = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int OUT_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mult_valid,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] addr_result,
   output logic                  rd_dout,
   input  logic [RAMWIDTH-1:0]   dout,
   output logic [RAMWIDTH-1:0]   m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int NWORDS = (N + RAMWIDTH - 1) / RAMWIDTH;
   localparam int TAIL   = N % RAMWIDTH;
   localparam int PW     = $clog2(OUT_DEPTH);
   localparam int CW     = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NWORDS - 1);
   // Keeps only the low TAIL bits of the final word (all bits when N fills it).
   localparam logic [RAMWIDTH-1:0] TAIL_MASK =
      (TAIL == 0) ? {RAMWIDTH{1'b1}} : ~({RAMWIDTH{1'b1}} << TAIL);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   state_t                  state, state_nxt;
   logic                    mult_valid_q;
   logic                    trigger;
   logic [ADDR_WIDTH-1:0]   rd_ptr;
   logic                    issue;
   logic [ADDR_WIDTH-1:0]   issue_addr;
   logic                    issue_last;

   // Read pipeline: p1 marks the read whose data is on dout this cycle.
   logic                    p1_valid;
   logic                    p1_last;
   logic [RAMWIDTH-1:0]     masked;
   logic [RAMWIDTH-1:0]     reordered;

   // Output FIFO, each entry is {last, data}.
   logic [RAMWIDTH:0]       fifo_mem [OUT_DEPTH];
   logic [PW-1:0]           wr_idx, rd_idx;
   logic [CW-1:0]           fifo_count;
   logic [RAMWIDTH:0]       head;
   logic                    wr_en;
   logic                    pop;
   logic [1:0]              inflight;
   logic [CW:0]             occupancy;
   logic                    space_ok;

   assign trigger   = mult_valid & ~mult_valid_q;
   assign inflight  = {1'b0, rd_dout} + {1'b0, p1_valid};
   // Reads in flight are counted as already occupying FIFO slots, so the FIFO
   // can never be overrun by data arriving after the downstream side stalls.
   assign occupancy = {1'b0, fifo_count} + {{(CW-1){1'b0}}, inflight};
   assign space_ok  = occupancy < (CW+1)'(OUT_DEPTH);

   assign head    = fifo_mem[rd_idx];
   assign m_valid = (fifo_count != '0);
   assign m_data  = m_valid ? head[RAMWIDTH-1:0] : '0;
   assign m_last  = m_valid & head[RAMWIDTH];
   assign pop     = m_valid & m_ready;
   assign wr_en   = p1_valid & ~abort;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (trigger) state_nxt = issue_last ? DRAIN : RUN;
         RUN:     if (issue_last) state_nxt = DRAIN;
         DRAIN:   if (pop && m_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // ---------------- FSM: outputs ----------------
   // The first read goes out on the trigger edge itself so data reaches the
   // FIFO two clocks later.
   always_comb begin
      issue      = 1'b0;
      issue_addr = rd_ptr;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            issue      = trigger;
            issue_addr = '0;
         end
         RUN:     issue = space_ok;
         default: issue = 1'b0;
      endcase
      if (abort) issue = 1'b0;
      issue_last = issue && (issue_addr == LAST_ADDR);
   end

   // ---------------- Mask and byte reorder ----------------
   always_comb begin
      masked    = p1_last ? (dout & TAIL_MASK) : dout;
      reordered = '0;
      for (int k = 0; k < RAMWIDTH / 8; k++)
         reordered[8*k +: 8] = masked[RAMWIDTH-8*k-8 +: 8];
   end

   // FIFO storage needs no reset: entries are only visible when counted.
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem[wr_idx] <= {p1_last, reordered};
   end

   // ---------------- Read issue, pipeline and FIFO control ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mult_valid_q <= 1'b0;
         addr_result  <= '0;
         rd_dout      <= 1'b0;
         rd_ptr       <= '0;
         p1_valid     <= 1'b0;
         p1_last      <= 1'b0;
         wr_idx       <= '0;
         rd_idx       <= '0;
         fifo_count   <= '0;
         done         <= 1'b0;
      end else begin
         mult_valid_q <= mult_valid;
         if (abort) begin
            // Queued words and reads still in the RAM pipeline are dropped.
            rd_dout    <= 1'b0;
            rd_ptr     <= '0;
            p1_valid   <= 1'b0;
            p1_last    <= 1'b0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            fifo_count <= '0;
            done       <= 1'b0;
         end else begin
            rd_dout <= issue;
            if (issue) begin
               addr_result <= issue_addr;
               rd_ptr      <= issue_addr + ADDR_WIDTH'(1);
            end
            p1_valid <= rd_dout;
            p1_last  <= rd_dout && (addr_result == LAST_ADDR);
            if (wr_en) wr_idx <= wr_idx + PW'(1);
            if (pop)   rd_idx <= rd_idx + PW'(1);
            case ({wr_en, pop})
               2'b10:   fifo_count <= fifo_count + CW'(1);
               2'b01:   fifo_count <= fifo_count - CW'(1);
               default: fifo_count <= fifo_count;
            endcase
            done <= pop && m_last;
         end
      end
   end

endmodule

// File: tb/tb_poly_mult_result_reader.sv
module tb_poly_mult_result_reader;

   localparam int N      = 17669;
   localparam int W      = 32;
   localparam int AW     = 11;
   localparam int NWORDS = 553;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          mult_valid = 1'b0;
   logic          abort = 1'b0;
   logic          m_ready = 1'b0;
   logic [AW-1:0] addr_result;
   logic          rd_dout;
   logic [W-1:0]  dout = '0;
   logic [W-1:0]  m_data;
   logic          m_valid, m_last, busy, done;

   poly_mult_result_reader dut (
      .clk(clk), .rst_n(rst_n), .mult_valid(mult_valid), .abort(abort),
      .addr_result(addr_result), .rd_dout(rd_dout), .dout(dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .busy(busy), .done(done)
   );

   // Result RAM: one-clock read latency.
   logic [W-1:0] ram [0:NWORDS-1];
   always @(posedge clk) if (rd_dout) dout <= ram[addr_result];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W:0]   exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           ready_mode = 0;
   int           hs_cnt, first_cyc, last_cyc, issued, consumed, trig_cyc;
   bit           done_seen, exp_done, prev_stall, prev_last;
   logic [W-1:0] prev_data;
   logic [W-1:0] got [0:NWORDS-1];

   // Reference: clear every bit at or above N, then reverse the byte order.
   function automatic logic [W:0] expect_word(int i);
      logic [W-1:0] w;
      logic [W-1:0] r;
      w = ram[i];
      for (int b = 0; b < W; b++)
         if (i * W + b >= N) w[b] = 1'b0;
      r = {<<8{w}};
      return {(i == NWORDS - 1), r};
   endfunction

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_done   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("done_pulse", {32'd0, done}, {32'd0, exp_done});
         if (done) done_seen = 1'b1;
         if (prev_stall) begin
            check("stall_hold", {m_last, m_data}, {prev_last, prev_data});
            check("stall_valid", {32'd0, m_valid}, 33'd1);
         end
         if (rd_dout) issued++;
         if (busy) check("outstanding_le_4", {32'd0, (issued - consumed) <= 4}, 33'd1);
         if (m_valid && first_cyc < 0) first_cyc = cyc;
         exp_done = 1'b0;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %h required none (cyc %0d)", m_data, cyc);
            end else begin
               check("beat", {m_last, m_data}, exp_q.pop_front());
            end
            if (hs_cnt < NWORDS) got[hs_cnt] = m_data;
            hs_cnt++;
            consumed++;
            if (m_last) begin
               last_cyc = cyc;
               exp_done = 1'b1;
            end
         end
         prev_stall = m_valid && !m_ready && !abort;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ($urandom_range(0, 99) < 40);
         default: m_ready = 1'b0;
      endcase
   endtask

   task automatic trigger();
      mult_valid = 1'b0;
      step();
      for (int i = 0; i < NWORDS; i++) exp_q.push_back(expect_word(i));
      hs_cnt = 0; first_cyc = -1; last_cyc = -1;
      issued = 0; consumed = 0; done_seen = 1'b0;
      mult_valid = 1'b1;
      step();
      trig_cyc = cyc;
   endtask

   task automatic run_until_beats(input int n, input int budget);
      int k;
      k = 0;
      while (hs_cnt < n && k < budget) begin
         step();
         k++;
      end
      check("beat_budget", {32'd0, hs_cnt >= n}, 33'd1);
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!done_seen && k < budget) begin
         step();
         k++;
      end
      step();
      check("done_seen", {32'd0, done_seen}, 33'd1);
      check("queue_empty", 33'(exp_q.size()), 33'd0);
      check("beat_count", 33'(hs_cnt), 33'(NWORDS));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_m_valid"}, {32'd0, m_valid}, 33'd0);
      check({tag, "_m_data"}, {1'b0, m_data}, 33'd0);
      check({tag, "_m_last"}, {32'd0, m_last}, 33'd0);
      check({tag, "_busy"}, {32'd0, busy}, 33'd0);
      check({tag, "_done"}, {32'd0, done}, 33'd0);
      check({tag, "_rd_dout"}, {32'd0, rd_dout}, 33'd0);
      check({tag, "_addr"}, {22'd0, addr_result}, 33'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int idle_busy;
      for (int i = 0; i < NWORDS; i++) ram[i] = {i[7:0], 8'hA5, 8'h3C, i[7:0]};
      repeat (3) step();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      step();

      // 1: full stream, latency and byte order
      ready_mode = 0;
      trigger();
      wait_done(2000);
      check("word1_reversed", {1'b0, got[1]}, {1'b0, 32'h013CA501});
      check("first_valid_latency", 33'(first_cyc - trig_cyc), 33'd2);
      check("last_beat_latency", 33'(last_cyc - trig_cyc), 33'(2 + NWORDS - 1));

      // mult_valid still high after done: no restart
      idle_busy = 0;
      repeat (20) begin
         step();
         if (busy || rd_dout || m_valid) idle_busy++;
      end
      check("no_retrigger_on_hold", 33'(idle_busy), 33'd0);

      // 2: tail masking
      ram[NWORDS-1] = 32'hFFFFFFFF;
      ram[0]        = 32'h11223344;
      trigger();
      wait_done(2000);
      check("beat0_value", {1'b0, got[0]}, {1'b0, 32'h44332211});
      check("beat552_masked", {1'b0, got[NWORDS-1]}, {1'b0, 32'h1F000000});

      // 3: random backpressure and a long stall
      for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;
      ready_mode = 1;
      trigger();
      run_until_beats(250, 3000);
      ready_mode = 2;
      repeat (50) step();
      ready_mode = 1;
      wait_done(5000);

      // 4: extra trigger edge mid-stream is ignored
      ready_mode = 0;
      trigger();
      run_until_beats(98, 500);
      mult_valid = 1'b0;
      run_until_beats(100, 500);
      mult_valid = 1'b1;
      wait_done(2000);

      // 5: asynchronous reset mid-stream
      for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;
      trigger();
      run_until_beats(200, 1000);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      exp_q.delete();
      mult_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      trigger();
      wait_done(2000);

      // 6: abort mid-stream
      trigger();
      run_until_beats(300, 1000);
      ready_mode = 2;
      m_ready = 1'b0;
      abort = 1'b1;
      exp_q.delete();
      step();
      abort = 1'b0;
      check("abort_m_valid", {32'd0, m_valid}, 33'd0);
      check("abort_busy", {32'd0, busy}, 33'd0);
      done_seen = 1'b0;
      repeat (10) step();
      check("abort_no_done", {32'd0, done_seen}, 33'd0);
      ready_mode = 0;
      trigger();
      wait_done(2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case a wait loop is defeated by a broken design.
   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout required completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
